key_cmd_decoder: RTL and testbench

KEY_CMD_DECODER -- requirements
Module: key_cmd_decoder

---
 rtl/key_cmd_decoder_pkg.sv | 67 ++++++
 rtl/key_cmd_decoder_repeat_timer.sv | 45 ++++
 rtl/key_cmd_decoder.sv | 120 ++++++++++++
 tb/tb_key_cmd_decoder.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/key_cmd_decoder_pkg.sv
// Shared keyboard definitions for the key command decoder.
//   - key_event bit positions (valid strobe, E0 prefix, break flag, scan code)
//   - PS/2 set-2 scan-code constants for every mapped key
//   - key index enumeration; its order is the bit order of the held bitmap
//   - decode_key(): one-hot key vector for a (E0, scan code) pair
package key_cmd_decoder_pkg;

    localparam int KEV_VALID  = 10;
    localparam int KEV_E0     = 9;
    localparam int KEV_BREAK  = 8;

    localparam int NUM_KEYS   = 15;  // width of the held bitmap
    localparam int NUM_MAPPED = 13;  // indices 13/14 are reserved, never set

    // Plain codes (E0 must be 0)
    localparam logic [7:0] SC_W     = 8'h1D;
    localparam logic [7:0] SC_A     = 8'h1C;
    localparam logic [7:0] SC_S     = 8'h1B;
    localparam logic [7:0] SC_D     = 8'h23;
    localparam logic [7:0] SC_BOOM1 = 8'h16;
    localparam logic [7:0] SC_BOOM2 = 8'h69;
    localparam logic [7:0] SC_PAUSE = 8'h4D;
    localparam logic [7:0] SC_SPACE = 8'h29;
    localparam logic [7:0] SC_RESET = 8'h2D;
    // Extended codes (E0 must be 1)
    localparam logic [7:0] SC_UP    = 8'h75;
    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_DOWN  = 8'h72;
    localparam logic [7:0] SC_RIGHT = 8'h74;

    typedef enum logic [3:0] {
        K_W, K_A, K_S, K_D, K_BOOM1, K_BOOM2, K_PAUSE, K_SPACE, K_RESET,
        K_UP, K_LEFT, K_DOWN, K_RIGHT, K_RSVD0, K_RSVD1
    } key_idx_e;

    // Keys with auto-repeat: A, S, D, LEFT, DOWN, RIGHT (bits 1,2,3,10,11,12)
    localparam logic [NUM_KEYS-1:0] REPEAT_MASK = 15'h1C0E;

    function automatic logic [NUM_KEYS-1:0] decode_key(input logic e0, input logic [7:0] code);
        logic [NUM_KEYS-1:0] v;
        v = '0;
        if (!e0) begin
            case (code)
                SC_W:     v[K_W]     = 1'b1;
                SC_A:     v[K_A]     = 1'b1;
                SC_S:     v[K_S]     = 1'b1;
                SC_D:     v[K_D]     = 1'b1;
                SC_BOOM1: v[K_BOOM1] = 1'b1;
                SC_BOOM2: v[K_BOOM2] = 1'b1;
                SC_PAUSE: v[K_PAUSE] = 1'b1;
                SC_SPACE: v[K_SPACE] = 1'b1;
                SC_RESET: v[K_RESET] = 1'b1;
                default:  v = '0;
            endcase
        end else begin
            case (code)
                SC_UP:    v[K_UP]    = 1'b1;
                SC_LEFT:  v[K_LEFT]  = 1'b1;
                SC_DOWN:  v[K_DOWN]  = 1'b1;
                SC_RIGHT: v[K_RIGHT] = 1'b1;
                default:  v = '0;
            endcase
        end
        return v;
    endfunction

endpackage

// File: rtl/key_cmd_decoder_repeat_timer.sv
// Auto-repeat timer for one key.
//   clk, rst : clock, async active-high reset (counter to 0)
//   load     : initial make of the key; start the first-repeat delay
//   clear    : break of the key; stop and zero the counter, suppress expiry
//   active   : key currently held; counter runs only while set
//   expire   : combinational one-cycle pulse when the counter is at 0
module repeat_timer #(
    parameter int DELAY  = 30_000_000,
    parameter int PERIOD = 8_000_000,
    parameter int CW     = 25
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic clear,
    input  logic active,
    output logic expire
);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d  = cnt_q;
        expire = 1'b0;
        if (clear) begin
            // break beats a same-cycle expiry
            cnt_d = '0;
        end else if (load) begin
            cnt_d = CW'(DELAY - 1);
        end else if (active) begin
            if (cnt_q == '0) begin
                expire = 1'b1;
                cnt_d  = CW'(PERIOD - 1);
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

endmodule

// File: rtl/key_cmd_decoder.sv
// PS/2 key event to game command decoder.
//   clk, rst      : clock, async active-high reset
//   key_event     : [10] valid, [9] E0, [8] break, [7:0] scan code
//   swap          : exchange player-1 / player-2 routing of command pulses
//   p1_*, p2_*    : per-player movement pulses (one cycle, registered)
//   boom1, boom2  : per-player special-action pulses
//   pause, space, game_reset : global command pulses
//   held          : held-key bitmap, bit order = key_idx_e
module key_cmd_decoder
    import key_cmd_decoder_pkg::*;
#(
    parameter int REPEAT_DELAY  = 30_000_000,
    parameter int REPEAT_PERIOD = 8_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [10:0] key_event,
    input  logic        swap,
    output logic        p1_up,
    output logic        p1_down,
    output logic        p1_left,
    output logic        p1_right,
    output logic        p2_up,
    output logic        p2_down,
    output logic        p2_left,
    output logic        p2_right,
    output logic        boom1,
    output logic        boom2,
    output logic        pause,
    output logic        space,
    output logic        game_reset,
    output logic [14:0] held
);

    localparam int CNT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    logic [NUM_KEYS-1:0]   hit, make_v, brk_v, new_press;
    logic [NUM_KEYS-1:0]   held_q, held_d;
    // Physical key state. Deliberately not reset: it remembers keys that
    // were down across a reset so their typematic resends are not taken as
    // fresh presses. It only updates outside reset.
    logic [NUM_KEYS-1:0]   down_q, down_d;
    wire  [NUM_MAPPED-1:0] expire;
    logic [NUM_MAPPED-1:0] key_pulse;
    logic [4:0]            grp_a, grp_b;   // {boom, right, left, down, up}
    logic [4:0]            p1_q, p1_d, p2_q, p2_d;
    logic [2:0]            glob_q, glob_d; // {game_reset, space, pause}

    always_comb begin
        hit       = key_event[KEV_VALID] ? decode_key(key_event[KEV_E0], key_event[7:0]) : '0;
        make_v    = key_event[KEV_BREAK] ? '0  : hit;
        brk_v     = key_event[KEV_BREAK] ? hit : '0;
        new_press = make_v & ~held_q & ~down_q;
        held_d    = (held_q | new_press) & ~brk_v;
        down_d    = (down_q | new_press) & ~brk_v;
        key_pulse = new_press[NUM_MAPPED-1:0] | expire;

        grp_a  = {key_pulse[K_BOOM1], key_pulse[K_D], key_pulse[K_A],
                  key_pulse[K_S], key_pulse[K_W]};
        grp_b  = {key_pulse[K_BOOM2], key_pulse[K_RIGHT], key_pulse[K_LEFT],
                  key_pulse[K_DOWN], key_pulse[K_UP]};
        p1_d   = swap ? grp_b : grp_a;
        p2_d   = swap ? grp_a : grp_b;
        glob_d = {key_pulse[K_RESET], key_pulse[K_SPACE], key_pulse[K_PAUSE]};
    end

    for (genvar k = 0; k < NUM_MAPPED; k++) begin : g_key
        if (REPEAT_MASK[k]) begin : g_rpt
            repeat_timer #(
                .DELAY  (REPEAT_DELAY),
                .PERIOD (REPEAT_PERIOD),
                .CW     (CW)
            ) u_timer (
                .clk    (clk),
                .rst    (rst),
                .load   (new_press[k]),
                .clear  (brk_v[k]),
                .active (held_q[k]),
                .expire (expire[k])
            );
        end else begin : g_norpt
            assign expire[k] = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            held_q <= '0;
            p1_q   <= '0;
            p2_q   <= '0;
            glob_q <= '0;
        end else begin
            held_q <= held_d;
            p1_q   <= p1_d;
            p2_q   <= p2_d;
            glob_q <= glob_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) down_q <= down_d;
    end

    assign p1_up      = p1_q[0];
    assign p1_down    = p1_q[1];
    assign p1_left    = p1_q[2];
    assign p1_right   = p1_q[3];
    assign boom1      = p1_q[4];
    assign p2_up      = p2_q[0];
    assign p2_down    = p2_q[1];
    assign p2_left    = p2_q[2];
    assign p2_right   = p2_q[3];
    assign boom2      = p2_q[4];
    assign pause      = glob_q[0];
    assign space      = glob_q[1];
    assign game_reset = glob_q[2];
    assign held       = held_q;

endmodule

// File: tb/tb_key_cmd_decoder.sv
module tb_key_cmd_decoder;

    localparam int DELAY  = 4;
    localparam int PERIOD = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [10:0] key_event;
    logic        swap;
    logic p1_up, p1_down, p1_left, p1_right, p2_up, p2_down, p2_left, p2_right;
    logic boom1, boom2, pause, space, game_reset;
    logic [14:0] held;

    key_cmd_decoder #(.REPEAT_DELAY(DELAY), .REPEAT_PERIOD(PERIOD)) dut (
        .clk(clk), .rst(rst), .key_event(key_event), .swap(swap),
        .p1_up(p1_up), .p1_down(p1_down), .p1_left(p1_left), .p1_right(p1_right),
        .p2_up(p2_up), .p2_down(p2_down), .p2_left(p2_left), .p2_right(p2_right),
        .boom1(boom1), .boom2(boom2), .pause(pause), .space(space),
        .game_reset(game_reset), .held(held)
    );

    always #5 clk = ~clk;

    // bit order: 0 p1_up 1 p1_down 2 p1_left 3 p1_right 4 p2_up 5 p2_down
    // 6 p2_left 7 p2_right 8 boom1 9 boom2 10 pause 11 space 12 game_reset
    wire [12:0] outs = {game_reset, space, pause, boom2, boom1, p2_right, p2_left,
                        p2_down, p2_up, p1_right, p1_left, p1_down, p1_up};

    // key table in held-bit order: W A S D b1 b2 P space R up left down right
    localparam bit [7:0] KCODE [13] = '{8'h1D, 8'h1C, 8'h1B, 8'h23, 8'h16, 8'h69,
                                        8'h4D, 8'h29, 8'h2D, 8'h75, 8'h6B, 8'h72, 8'h74};
    localparam bit       KE0   [13] = '{0,0,0,0,0,0,0,0,0,1,1,1,1};
    localparam bit       KRPT  [13] = '{0,1,1,1,0,0,0,0,0,0,1,1,1};
    localparam int       KOUT  [13] = '{0,2,1,3,8,9,10,11,12,4,6,5,7};

    int checks = 0;
    int failures = 0;
    int t = 0;
    bit m_held [13];
    bit m_down [13];
    int m_press [13];

    function automatic int find_key(input logic [10:0] ev);
        for (int j = 0; j < 13; j++)
            if (ev[10] && KCODE[j] == ev[7:0] && KE0[j] == ev[9]) return j;
        return -1;
    endfunction

    function automatic int route(input int b, input logic sw);
        if (sw && b < 8) return b ^ 4;
        if (sw && (b == 8 || b == 9)) return b ^ 1;
        return b;
    endfunction

    function automatic logic [14:0] m_held_vec();
        logic [14:0] v = '0;
        for (int j = 0; j < 13; j++) v[j] = m_held[j];
        return v;
    endfunction

    // Reference: per key, a new press pulses immediately; a held repeatable
    // key pulses when the time since its press is DELAY + n*PERIOD; a break
    // releases and suppresses everything for that key.
    task automatic model_step(input logic [10:0] ev, input logic sw, output logic [12:0] eo);
        int k;
        bit pulse;
        k = find_key(ev);
        eo = '0;
        for (int j = 0; j < 13; j++) begin
            pulse = 0;
            if (k == j && ev[8]) begin
                m_held[j] = 0;
                m_down[j] = 0;
            end else if (k == j && !m_held[j] && !m_down[j]) begin
                m_held[j] = 1;
                m_down[j] = 1;
                m_press[j] = t;
                pulse = 1;
            end else if (m_held[j] && KRPT[j] && (t - m_press[j]) >= DELAY &&
                         ((t - m_press[j] - DELAY) % PERIOD) == 0) begin
                pulse = 1;
            end
            if (pulse) eo[route(KOUT[j], sw)] = 1'b1;
        end
        t++;
    endtask

    // Drive one cycle and return model expectation plus DUT outputs after the edge.
    task automatic cyc(input logic [10:0] ev, input logic sw,
                       output logic [12:0] eo, output logic [14:0] eh,
                       output logic [12:0] go, output logic [14:0] gh);
        key_event = ev;
        swap = sw;
        model_step(ev, sw, eo);
        eh = m_held_vec();
        @(posedge clk);
        #1;
        go = outs;
        gh = held;
    endtask

    task automatic test_reset();
        logic [12:0] eo, go;
        logic [14:0] eh, gh;
        rst = 1'b1; key_event = '0; swap = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (outs !== 13'h0) begin failures++; $display("FAIL reset_outs got=%h exp=0", outs); end
        checks++;
        if (held !== 15'h0) begin failures++; $display("FAIL reset_held got=%h exp=0", held); end
        rst = 1'b0;
        // release every key so the physical-state tracking starts known
        for (int j = 0; j < 13; j++) begin
            cyc({1'b1, KE0[j], 1'b1, KCODE[j]}, 1'b0, eo, eh, go, gh);
            checks++;
            if (go !== eo || gh !== eh) begin
                failures++;
                $display("FAIL flush j=%0d out=%h exp=%h held=%h exp=%h", j, go, eo, gh, eh);
            end
        end
    endtask

    task automatic test_make_break();
        logic [12:0] eo, go;
        logic [14:0] eh, gh;
        logic [15:0] up_mask = '0;
        logic [10:0] ev;
        for (int c = 0; c < 8; c++) begin
            ev = (c == 0) ? 11'h41D : (c == 4) ? 11'h51D : 11'h000;
            cyc(ev, 1'b0, eo, eh, go, gh);
            checks++;
            if (go !== eo || gh !== eh) begin
                failures++;
                $display("FAIL make_break c=%0d out=%h exp=%h held=%h exp=%h", c, go, eo, gh, eh);
            end
            up_mask[c+1] = go[0];
            if (c == 1) begin
                checks++;
                if (gh[0] !== 1'b1) begin failures++; $display("FAIL make_break_held got=%b exp=1", gh[0]); end
            end
        end
        checks++;
        if (up_mask !== 16'h0002) begin failures++; $display("FAIL p1_up_cycles got=%h exp=0002", up_mask); end
        checks++;
        if (held[0] !== 1'b0) begin failures++; $display("FAIL break_held got=%b exp=0", held[0]); end
    endtask

    task automatic test_repeat();
        logic [12:0] eo, go;
        logic [14:0] eh, gh;
        logic [15:0] mask = '0;
        logic [10:0] ev;
        for (int c = 0; c < 15; c++) begin
            ev = (c == 0) ? 11'h66B : (c == 12) ? 11'h76B : 11'h000;
            cyc(ev, 1'b0, eo, eh, go, gh);
            checks++;
            if (go !== eo || gh !== eh) begin
                failures++;
                $display("FAIL repeat c=%0d out=%h exp=%h held=%h exp=%h", c, go, eo, gh, eh);
            end
            mask[c+1] = go[6];
        end
        checks++;
        if (mask !== 16'h0AA2) begin failures++; $display("FAIL p2_left_cycles got=%h exp=0aa2", mask); end
    endtask

    task automatic test_typematic();
        logic [12:0] eo, go;
        logic [14:0] eh, gh;
        int n_up = 0;
        logic [10:0] ev;
        for (int c = 0; c < 12; c++) begin
            ev = (c == 0 || c == 3 || c == 6) ? 11'h41D : (c == 9) ? 11'h51D : 11'h000;
            cyc(ev, 1'b0, eo, eh, go, gh);
            checks++;
            if (go !== eo || gh !== eh) begin
                failures++;
                $display("FAIL typematic_w c=%0d out=%h exp=%h held=%h exp=%h", c, go, eo, gh, eh);
            end
            n_up += int'(go[0]);
        end
        checks++;
        if (n_up != 1) begin failures++; $display("FAIL typematic_count got=%0d exp=1", n_up); end
        for (int c = 0; c < 10; c++) begin
            ev = (c == 0 || c == 3 || c == 6) ? 11'h41C : (c == 8) ? 11'h51C : 11'h000;
            cyc(ev, 1'b0, eo, eh, go, gh);
            checks++;
            if (go !== eo || gh !== eh) begin
                failures++;
                $display("FAIL typematic_a c=%0d out=%h exp=%h held=%h exp=%h", c, go, eo, gh, eh);
            end
        end
    endtask

    task automatic test_swap();
        logic [12:0] eo, go;
        logic [14:0] eh, gh;
        cyc(11'h423, 1'b1, eo, eh, go, gh);
        checks++;
        if (go[7] !== 1'b1 || go[3] !== 1'b0) begin
            failures++; $display("FAIL swap_d got p2_right=%b p1_right=%b exp 1 0", go[7], go[3]);
        end
        cyc(11'h523, 1'b1, eo, eh, go, gh);
        cyc(11'h674, 1'b0, eo, eh, go, gh);
        checks++;
        if (go[7] !== 1'b1 || go[3] !== 1'b0) begin
            failures++; $display("FAIL noswap_right got p2_right=%b p1_right=%b exp 1 0", go[7], go[3]);
        end
        // toggle swap while right arrow auto-repeats
        for (int c = 0; c < 12; c++) begin
            cyc((c == 11) ? 11'h774 : 11'h000, c[1], eo, eh, go, gh);
            checks++;
            if (go !== eo || gh !== eh) begin
                failures++;
                $display("FAIL swap_repeat c=%0d out=%h exp=%h held=%h exp=%h", c, go, eo, gh, eh);
            end
        end
    endtask

    task automatic test_ignore();
        logic [12:0] eo, go;
        logic [14:0] eh, gh;
        logic [10:0] evs [6] = '{11'h475, 11'h61D, 11'h31D, 11'h4FF, 11'h012, 11'h67A};
        for (int i = 0; i < 6; i++) begin
            cyc(evs[i], 1'b0, eo, eh, go, gh);
            checks++;
            if (go !== 13'h0 || gh !== eh) begin
                failures++;
                $display("FAIL ignore ev=%h out=%h exp=0 held=%h exp=%h", evs[i], go, gh, eh);
            end
        end
    endtask

    task automatic test_simultaneous();
        logic [12:0] eo, go;
        logic [14:0] eh, gh;
        logic [10:0] ev;
        for (int c = 0; c < 12; c++) begin
            ev = (c == 0) ? 11'h41C : (c == 2) ? 11'h41B : (c == 6) ? 11'h44D :
                 (c == 9) ? 11'h51C : (c == 10) ? 11'h51B : (c == 11) ? 11'h54D : 11'h000;
            cyc(ev, 1'b0, eo, eh, go, gh);
            checks++;
            if (go !== eo || gh !== eh) begin
                failures++;
                $display("FAIL simul c=%0d out=%h exp=%h held=%h exp=%h", c, go, eo, gh, eh);
            end
            if (c == 6) begin
                checks++;
                if (go !== 13'h0406) begin failures++; $display("FAIL simul_cycle7 got=%h exp=0406", go); end
            end
        end
    endtask

    task automatic test_reset_held();
        logic [12:0] eo, go;
        logic [14:0] eh, gh;
        logic [31:0] mask = '0;
        logic [10:0] ev;
        for (int c = 0; c < 6; c++) begin
            cyc((c == 0) ? 11'h41B : 11'h000, 1'b0, eo, eh, go, gh);
            checks++;
            if (go !== eo || gh !== eh) begin
                failures++;
                $display("FAIL pre_rst c=%0d out=%h exp=%h held=%h exp=%h", c, go, eo, gh, eh);
            end
        end
        key_event = '0;
        rst = 1'b1;
        #1;
        checks++;
        if (outs !== 13'h0 || held !== 15'h0) begin
            failures++; $display("FAIL async_rst out=%h held=%h exp 0 0", outs, held);
        end
        for (int j = 0; j < 13; j++) m_held[j] = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int c = 0; c < 14; c++) begin
            ev = (c == 3) ? 11'h41B : (c == 6) ? 11'h41B : (c == 8) ? 11'h51B :
                 (c == 10) ? 11'h41B : (c == 13) ? 11'h51B : 11'h000;
            cyc(ev, 1'b0, eo, eh, go, gh);
            checks++;
            if (go !== eo || gh !== eh) begin
                failures++;
                $display("FAIL post_rst c=%0d out=%h exp=%h held=%h exp=%h", c, go, eo, gh, eh);
            end
            mask[c+1] = go[1];
        end
        checks++;
        if (mask !== 32'h0000_0800) begin failures++; $display("FAIL post_rst_down got=%h exp=00000800", mask); end
    endtask

    task automatic test_random();
        logic [12:0] eo, go;
        logic [14:0] eh, gh;
        logic [10:0] ev;
        logic sw = 1'b0;
        int r, j;
        for (int c = 0; c < 400; c++) begin
            r = $urandom_range(0, 9);
            j = $urandom_range(0, 12);
            if (r < 7)       ev = {1'b1, KE0[j], ($urandom_range(0, 2) == 0), KCODE[j]};
            else if (r == 7) ev = 11'h000;
            else if (r == 8) ev = {1'b1, ~KE0[j], 1'b0, KCODE[j]};
            else             ev = 11'($urandom);
            if ($urandom_range(0, 7) == 0) sw = ~sw;
            cyc(ev, sw, eo, eh, go, gh);
            checks++;
            if (go !== eo || gh !== eh) begin
                failures++;
                $display("FAIL random c=%0d ev=%h out=%h exp=%h held=%h exp=%h", c, ev, go, eo, gh, eh);
            end
        end
    endtask

    initial begin
        test_reset();
        test_make_break();
        test_repeat();
        test_typematic();
        test_swap();
        test_ignore();
        test_simultaneous();
        test_reset_held();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
